// File: rtl/arb2_rr_mux_ctrl.sv
// Two-requester round-robin arbiter that steers a shared 2:1 data mux.
// Each grant is held until the owner releases it, its request drops, or MAX_HOLD cycles pass.
module arb2_rr_mux_ctrl #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic              done,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic [1:0]        grant,
  output logic              sel,
  output logic [DATA_W-1:0] out,
  output logic              valid
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            enter_s;
  logic [CW-1:0]   cnt_r;
  logic            ptr_r;
  logic [1:0]      grant_r;
  logic            sel_r;
  logic            valid_r;

  // Next-state decision; enter_s marks any edge that starts a fresh grant, including a re-grant.
  always_comb begin
    state_nxt_s = state_r;
    enter_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req == 2'b11) begin
          state_nxt_s = ptr_r ? GNT1 : GNT0;
          enter_s     = 1'b1;
        end else if (req[0]) begin
          state_nxt_s = GNT0;
          enter_s     = 1'b1;
        end else if (req[1]) begin
          state_nxt_s = GNT1;
          enter_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          enter_s     = 1'b0;
        end
      end
      GNT0: begin
        if (!req[0] || done || (cnt_r == CNT_LAST)) begin
          if (req[1]) begin
            state_nxt_s = GNT1;
            enter_s     = 1'b1;
          end else if (req[0]) begin
            state_nxt_s = GNT0;
            enter_s     = 1'b1;
          end else begin
            state_nxt_s = IDLE;
            enter_s     = 1'b0;
          end
        end else begin
          state_nxt_s = GNT0;
          enter_s     = 1'b0;
        end
      end
      GNT1: begin
        if (!req[1] || done || (cnt_r == CNT_LAST)) begin
          if (req[0]) begin
            state_nxt_s = GNT0;
            enter_s     = 1'b1;
          end else if (req[1]) begin
            state_nxt_s = GNT1;
            enter_s     = 1'b1;
          end else begin
            state_nxt_s = IDLE;
            enter_s     = 1'b0;
          end
        end else begin
          state_nxt_s = GNT1;
          enter_s     = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        enter_s     = 1'b0;
      end
    endcase
  end

  // State, hold counter, priority pointer and the registered grant outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      ptr_r   <= 1'b0;
      grant_r <= 2'b00;
      sel_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (enter_s) begin
        cnt_r <= CNT_ZERO;
        // The requester just granted drops to lowest priority.
        ptr_r <= (state_nxt_s == GNT0);
      end else if (state_nxt_s != IDLE) begin
        cnt_r <= cnt_r + CNT_ONE;
        ptr_r <= ptr_r;
      end else begin
        cnt_r <= CNT_ZERO;
        ptr_r <= ptr_r;
      end
      grant_r <= {(state_nxt_s == GNT1), (state_nxt_s == GNT0)};
      sel_r   <= (state_nxt_s == GNT1);
      valid_r <= (state_nxt_s != IDLE);
    end
  end

  assign grant = grant_r;
  assign sel   = sel_r;
  assign valid = valid_r;
  assign out   = sel_r ? in1 : in0;

endmodule

// File: doc/arb2_rr_mux_ctrl.md
Name: arb2_rr_mux_ctrl

Overview:
- Round-robin arbiter that shares one 2:1 data mux between two requesters. It drives the mux select and a one-hot grant.
- Sits in front of any shared single-consumer resource, such as a display bus or memory write port.
- A grant is held until the owner releases it or a hold-timeout expires, so neither requester can starve the other.

Parameters:
- DATA_W, 8: width of each requester data word and of the muxed output.
- MAX_HOLD, 8: maximum consecutive cycles one requester may hold the grant. Legal range is 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  req[i]=1: requester i wants the resource. Level-sensitive.
- done  input  1  one-cycle pulse from the current owner: release the grant at this edge.
- in0  input  DATA_W  data from requester 0.
- in1  input  DATA_W  data from requester 1.
- grant  output  2  one-hot registered grant; 2'b00 when idle.
- sel  output  1  mux select; equals grant[1].
- out  output  DATA_W  muxed data: in1 when sel=1, else in0. Combinational from sel and inputs.
- valid  output  1  high when any grant is active (|grant).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.

Reset state (applies on the edge where reset=1):
- state=IDLE, grant=2'b00, sel=0, valid=0.
- Priority pointer favours requester 0.
- Hold counter is 0.
- out then follows in0.

States:
- IDLE, GNT0, GNT1.
- grant is 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE.
- sel and valid derive directly from the registered state, so they never glitch between edges.

Grant latency:
- A request seen in IDLE at edge N produces a grant visible after edge N (one cycle).

IDLE transitions:
- One requester high: go to that requester's grant state.
- Both high: grant the requester named by the priority pointer.
- Neither high: stay in IDLE.

GNTi release conditions (at an edge, any of):
- req[i]=0
- done=1
- hold counter == MAX_HOLD-1

GNTi hold behaviour:
- Hold counter resets to 0 on entry to any grant state and increments each cycle held.
- The counter saturates logically via the timeout, so the grant is never active for more than MAX_HOLD consecutive cycles.
- No release condition: stay in GNTi.

On release from GNTi:
- Other requester req[1-i]=1: go directly to GNT(1-i) on the same edge. There is no idle bubble.
- Else, req[i]=1 and the release cause was timeout or done: re-grant GNTi with the counter restarted. This takes one cycle in GNTi at count 0, not a bubble.
- Else: go to IDLE.

Priority pointer:
- Updated on every grant entry: the requester just granted becomes lowest priority.
- Re-grant of the same requester keeps it lowest.

Simultaneous events:
- done together with req[i] dropping: a single release.
- done asserted while in IDLE: ignored.
- req changes on the same edge as a release use the sampled value at that edge.

Reset mid-operation:
- grant, sel and valid are 0 after the reset edge, regardless of state.
- Pointer returns to favour requester 0.

Widths:
- Hold counter is $clog2(MAX_HOLD) bits.
- No arithmetic on data; out is a pure select.

Test Plan:
1. Reset, then req=2'b01, in0=8'hA5, in1=8'h3C -> after one edge grant=01, sel=0, valid=1, out=8'hA5. Drop req -> next edge grant=00, valid=0.
2. From IDLE with pointer at reset value, req=2'b11 -> grant=01. Pulse done -> next edge grant=10, sel=1, out=8'h3C with no idle cycle. Pulse done again -> grant=01.
3. Timeout with MAX_HOLD=8: hold req=2'b11 steadily -> grant alternates 01 for 8 cycles, then 10 for 8 cycles. Never more than 8 consecutive cycles on one requester.
4. Timeout with lone requester: req=2'b10 held for 20 cycles -> grant=10 throughout. Hold counter restarts every 8 cycles and valid never drops.
5. Reset mid-grant: in GNT1 at count 3, assert reset for one cycle -> grant=00, sel=0, out=in0 after that edge. Then req=2'b11 -> grant=01, because the pointer was reset.
6. Simultaneous release: in GNT0, done=1 and req=2'b10 on the same edge -> single transition to grant=10. done=1 with req=00 in IDLE -> grant stays 00.
